ram_bank_group: RTL
===================

RAM_BANK_GROUP -- requirements
Module: ram_bank_group

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-address width per bank; depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter BANK_CNT, default 2, meaning number of true dual-port banks; must be a power of two and >=2.
REQ-004 SHALL have parameter WRITE_FIRST, default 1, meaning 1 = a read returns the data written in the same cycle by the same port, 0 = it returns the old data.
REQ-005 SHALL derive BSW = log2(BANK_CNT) and AW = ADDR_WIDTH+BSW; the request address is {bank[BSW-1:0], word[ADDR_WIDTH-1:0]}.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 init_done  output  1  high once the post-reset clear sweep has finished.
REQ-010 For each port p in {a, b}: p_req_vld  input  1  request valid.
REQ-011 p_req_rdy  output  1  request accepted when p_req_vld & p_req_rdy.
REQ-012 p_req_we  input  1  1 = write, 0 = read.
REQ-013 p_req_addr  input  AW  bank and word address.
REQ-014 p_req_be  input  DATA_WIDTH/8  byte enables; used for writes only.
REQ-015 p_req_din  input  DATA_WIDTH  write data.
REQ-016 p_resp_vld  output  1  read data valid; one-cycle pulse.
REQ-017 p_resp_dout  output  DATA_WIDTH  read data.

Function
REQ-018 SHALL implement a two-state FSM, CLEAR -> RUN. The FSM enters CLEAR on reset; RUN is terminal until the next reset.
REQ-019 In CLEAR, a counter clr_ptr SHALL run from 0 to 2^ADDR_WIDTH-1, writing all-zero words at clr_ptr into every bank, one word per cycle, in parallel.
REQ-020 After the write at clr_ptr = 2^ADDR_WIDTH-1, the FSM SHALL enter RUN on the next edge and init_done SHALL go high; the clear takes exactly 2^ADDR_WIDTH cycles after reset release.
REQ-021 p_req_rdy SHALL be 0 in CLEAR and 1 in RUN; requests presented during CLEAR are ignored, not queued.
REQ-022 An accepted write SHALL update only the bytes whose p_req_be bit is 1 at bank = addr[AW-1:ADDR_WIDTH], word = addr[ADDR_WIDTH-1:0].
REQ-023 Every accepted request, read or write, SHALL produce p_resp_vld = 1 exactly one cycle later, with p_resp_dout = the addressed word.
REQ-024 For a write, p_resp_dout SHALL be the post-write word if WRITE_FIRST=1, or the pre-write word if WRITE_FIRST=0.
REQ-025 Ports a and b SHALL be fully independent and may access the same bank in the same cycle; there is no backpressure in RUN.
REQ-026 Same bank, same word, both ports writing in the same cycle: bytes enabled on port a take a's data; bytes enabled only on b take b's data.
REQ-027 Same bank, same word, one port reads while the other writes: the reader SHALL return the pre-write word.
REQ-028 p_resp_dout SHALL hold its last value while p_resp_vld = 0.
REQ-029 Address wrap is not applicable; every AW-bit address is valid.

Reset
REQ-030 On rst assertion, at any time including mid-CLEAR or mid-RUN: FSM = CLEAR, clr_ptr = 0, init_done = 0, p_req_rdy = 0, p_resp_vld = 0, p_resp_dout = 0, all immediately and asynchronously.
REQ-031 Memory contents are not reset directly; they are zeroed by the clear sweep after rst deasserts.
REQ-032 A response pending at reset assertion SHALL be dropped.

Verification
REQ-033 Release rst -> init_done and *_req_rdy rise exactly 256 cycles later (ADDR_WIDTH=8); then a read of every address in both banks returns 0.
REQ-034 a writes 0x1122334455667788 to addr 0x105 with be=0xFF; the next cycle b reads 0x105 -> b_resp_vld one cycle later, data 0x1122334455667788.
REQ-035 Word at 0x005 = 0; a writes 0xFFFFFFFFFFFFFFFF with be=0x0F; then read -> 0x00000000FFFFFFFF.
REQ-036 Same cycle: a writes 0xAA..AA (be=0xF0) and b writes 0x55..55 (be=0xFF), both to 0x010 -> later read returns 0xAAAAAAAA55555555.
REQ-037 a writes 0x1 to 0x020 (holding 0x7), WRITE_FIRST=1 vs 0 -> a_resp_dout = 0x1 vs 0x7; a simultaneous b read of 0x020 returns 0x7 in both modes.
REQ-038 Assert rst at clr_ptr = 100 and during a RUN read -> outputs go to their reset values immediately, the response is dropped, and the full clear restarts and completes 256 cycles after release.

Source files
------------

// File: rtl/ram_bank_group.sv
// Banked true dual-port RAM with byte enables and a post-reset zeroing sweep.
// Each port returns a one-cycle-latency response for every accepted request.
module ram_bank_group #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int BANK_CNT    = 2,
    parameter int WRITE_FIRST = 1,
    localparam int BSW   = $clog2(BANK_CNT),
    localparam int AW    = ADDR_WIDTH + BSW,
    localparam int BEW   = DATA_WIDTH / 8,
    localparam int DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  a_req_vld,
    output logic                  a_req_rdy,
    input  logic                  a_req_we,
    input  logic [AW-1:0]         a_req_addr,
    input  logic [BEW-1:0]        a_req_be,
    input  logic [DATA_WIDTH-1:0] a_req_din,
    output logic                  a_resp_vld,
    output logic [DATA_WIDTH-1:0] a_resp_dout,
    input  logic                  b_req_vld,
    output logic                  b_req_rdy,
    input  logic                  b_req_we,
    input  logic [AW-1:0]         b_req_addr,
    input  logic [BEW-1:0]        b_req_be,
    input  logic [DATA_WIDTH-1:0] b_req_din,
    output logic                  b_resp_vld,
    output logic [DATA_WIDTH-1:0] b_resp_dout
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    clr_en, run;
    logic [DATA_WIDTH-1:0]   mem [BANK_CNT][DEPTH];

    logic                    a_acc, b_acc, a_wr, b_wr, same_addr;
    logic [BSW-1:0]          a_bank, b_bank;
    logic [ADDR_WIDTH-1:0]   a_word, b_word;
    logic [DATA_WIDTH-1:0]   a_old, b_old, a_post, b_post, a_rd_data, b_rd_data;
    logic                    a_resp_vld_q, b_resp_vld_q;
    logic [DATA_WIDTH-1:0]   a_resp_dout_q, b_resp_dout_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BEW-1:0]        be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < BEW; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
            if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        clr_en = (state_q == CLEAR);
        run    = (state_q == RUN);
    end

    assign init_done = run;
    assign a_req_rdy = run;
    assign b_req_rdy = run;

    assign a_acc     = a_req_vld & run;
    assign b_acc     = b_req_vld & run;
    assign a_wr      = a_acc & a_req_we;
    assign b_wr      = b_acc & b_req_we;
    assign a_bank    = a_req_addr[AW-1:ADDR_WIDTH];
    assign b_bank    = b_req_addr[AW-1:ADDR_WIDTH];
    assign a_word    = a_req_addr[ADDR_WIDTH-1:0];
    assign b_word    = b_req_addr[ADDR_WIDTH-1:0];
    assign same_addr = (a_req_addr == b_req_addr);
    assign a_old     = mem[a_bank][a_word];
    assign b_old     = mem[b_bank][b_word];

    // Resulting word per port address; b's bytes first so a wins on overlap.
    always_comb begin
        a_post = a_old;
        if (b_wr && same_addr) a_post = merge_bytes(a_post, b_req_din, b_req_be);
        if (a_wr)              a_post = merge_bytes(a_post, a_req_din, a_req_be);
        b_post = b_old;
        if (b_wr)              b_post = merge_bytes(b_post, b_req_din, b_req_be);
        if (a_wr && same_addr) b_post = merge_bytes(b_post, a_req_din, a_req_be);
    end

    // A reader always sees the pre-write word; a writer sees its own result if write-first.
    assign a_rd_data = (a_req_we && WRITE_FIRST != 0) ? a_post : a_old;
    assign b_rd_data = (b_req_we && WRITE_FIRST != 0) ? b_post : b_old;

    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int bk = 0; bk < BANK_CNT; bk++) mem[bk][clr_ptr_q] <= '0;
        end else begin
            if (b_wr) mem[b_bank][b_word] <= b_post;
            if (a_wr) mem[a_bank][a_word] <= a_post;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_resp_vld_q  <= 1'b0;
            b_resp_vld_q  <= 1'b0;
            a_resp_dout_q <= '0;
            b_resp_dout_q <= '0;
        end else begin
            a_resp_vld_q <= a_acc;
            b_resp_vld_q <= b_acc;
            if (a_acc) a_resp_dout_q <= a_rd_data;
            if (b_acc) b_resp_dout_q <= b_rd_data;
        end
    end

    assign a_resp_vld  = a_resp_vld_q;
    assign b_resp_vld  = b_resp_vld_q;
    assign a_resp_dout = a_resp_dout_q;
    assign b_resp_dout = b_resp_dout_q;

endmodule
